// File: rtl/md_unit.sv
// md_unit: HI/LO registers and multi-cycle mult/multu/div/divu for the EX stage.
// Define MD_UNIT_MADD_EN to add madd/maddu (accumulate into {HI,LO}).
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        hi_write,
   input  logic        lo_write,
   input  logic        req,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);
   localparam int CMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, div_q, div_d, sgn_q, sgn_d;
   logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic          valid, launch, is_div, sa, sb, div_zero;
   logic [31:0]   abs_a, abs_b, qm, rm;
   logic [63:0]   prod, res;
`ifdef MD_UNIT_MADD_EN
   logic          mac_q, mac_d;
   assign valid = md_op <= 3'd5;
`else
   assign valid = ~md_op[2];
`endif
   assign is_div = md_op[1] & ~md_op[2];
   assign launch = start & ~req & ~busy_q & valid;
   // One 64-bit multiplier and one unsigned divider serve both signed and unsigned ops
   assign sa       = sgn_q & a_q[31];
   assign sb       = sgn_q & b_q[31];
   assign prod     = {{32{sa}}, a_q} * {{32{sb}}, b_q};
   assign abs_a    = sa ? -a_q : a_q;
   assign abs_b    = sb ? -b_q : b_q;
   assign qm       = abs_a / abs_b;
   assign rm       = abs_a % abs_b;
   assign div_zero = div_q & (b_q == 32'd0);
`ifdef MD_UNIT_MADD_EN
   assign res = div_q ? {sa ? -rm : rm, (sa ^ sb) ? -qm : qm}
                      : prod + (mac_q ? {hi_q, lo_q} : 64'd0);
`else
   assign res = div_q ? {sa ? -rm : rm, (sa ^ sb) ? -qm : qm} : prod;
`endif
   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      div_d = div_q;
      sgn_d = sgn_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
`ifdef MD_UNIT_MADD_EN
      mac_d = mac_q;
`endif
      if (launch) begin
         cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         a_d   = rs_data;
         b_d   = rt_data;
         div_d = is_div;
         sgn_d = ~md_op[0];
`ifdef MD_UNIT_MADD_EN
         mac_d = md_op[2];
`endif
      end else if (busy_q) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1) && !div_zero) {hi_d, lo_d} = res;
      end else if (!req) begin
         hi_d = hi_write ? rs_data : hi_q;
         lo_d = lo_write ? rs_data : lo_q;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         div_q  <= 1'b0;
         sgn_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
`ifdef MD_UNIT_MADD_EN
         mac_q  <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= cnt_d != '0;
         a_q    <= a_d;
         b_q    <= b_d;
         div_q  <= div_d;
         sgn_q  <= sgn_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
`ifdef MD_UNIT_MADD_EN
         mac_q  <= mac_d;
`endif
      end
   end
   assign busy   = busy_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; expected HI/LO/busy length queued at launch.
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;
   logic        clk = 0, reset = 1, start = 0, hi_write = 0, lo_write = 0, req = 0;
   logic [2:0]  md_op = 0;
   logic [31:0] rs_data = 0, rt_data = 0;
   logic        busy;
   logic [31:0] hi_out, lo_out;
   int          total = 0, bad = 0;
   logic [31:0] m_hi = 0, m_lo = 0;
   typedef struct {logic [31:0] hi; logic [31:0] lo; int cyc;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .rs_data(rs_data), .rt_data(rt_data), .hi_write(hi_write),
      .lo_write(lo_write), .req(req), .busy(busy),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint sa, sbv, r, q;
      longint unsigned ua, ub, ur, acc;
      sa = longint'($signed(a));
      sbv = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      acc = {m_hi, m_lo};
      e.hi = m_hi; e.lo = m_lo; e.cyc = 0;
      case (op)
         3'd0: begin r = sa * sbv; e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = MC; end
         3'd1: begin ur = ua * ub; e.hi = ur[63:32]; e.lo = ur[31:0]; e.cyc = MC; end
         3'd2: begin
            e.cyc = DC;
            if (b != 0) begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
         end
         3'd3: begin
            e.cyc = DC;
            if (b != 0) begin ur = ua / ub; e.lo = ur[31:0]; ur = ua % ub; e.hi = ur[31:0]; end
         end
`ifdef MD_UNIT_MADD_EN
         3'd4: begin r = sa * sbv; ur = acc + longint'(r); e.hi = ur[63:32]; e.lo = ur[31:0]; e.cyc = MC; end
         3'd5: begin ur = acc + ua * ub; e.hi = ur[63:32]; e.lo = ur[31:0]; e.cyc = MC; end
`endif
         default: ;
      endcase
      return e;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit r, input bit poke);
      exp_t e;
      int n;
      e = model(op, a, b);
      if (r) begin e.hi = m_hi; e.lo = m_lo; e.cyc = 0; end
      sb.push_back(e);
      md_op = op; rs_data = a; rt_data = b; req = r; start = 1;
      @(posedge clk); #1;
      start = 0; req = 0;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         total++;
         if (hi_out !== m_hi || lo_out !== m_lo) begin
            bad++;
            $display("FAIL hold op=%0d cyc=%0d: hi=%h lo=%h expected hi=%h lo=%h", op, n, hi_out, lo_out, m_hi, m_lo);
         end
         if (poke && n == 1) begin
            start = 1; md_op = 3'd1; rs_data = 32'd5; rt_data = 32'd9; hi_write = 1; lo_write = 1;
         end
         @(posedge clk); #1;
         start = 0; hi_write = 0; lo_write = 0;
         n++;
      end
      e = sb.pop_front();
      total++;
      if (n !== e.cyc) begin
         bad++;
         $display("FAIL busy_len op=%0d: got %0d expected %0d", op, n, e.cyc);
      end
      total++;
      if (hi_out !== e.hi) begin
         bad++;
         $display("FAIL hi op=%0d a=%h b=%h: got %h expected %h", op, a, b, hi_out, e.hi);
      end
      total++;
      if (lo_out !== e.lo) begin
         bad++;
         $display("FAIL lo op=%0d a=%h b=%h: got %h expected %h", op, a, b, lo_out, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
   endtask

   task automatic mt(input bit hw, input bit lw, input logic [31:0] v, input bit r);
      hi_write = hw; lo_write = lw; rs_data = v; req = r;
      @(posedge clk); #1;
      hi_write = 0; lo_write = 0; req = 0;
      if (!r) begin
         if (hw) m_hi = v;
         if (lw) m_lo = v;
      end
      total++;
      if (hi_out !== m_hi) begin bad++; $display("FAIL mt_hi: got %h expected %h", hi_out, m_hi); end
      total++;
      if (lo_out !== m_lo) begin bad++; $display("FAIL mt_lo: got %h expected %h", lo_out, m_lo); end
   endtask

   task automatic test_reset;
      int n;
      #1 reset = 0;
      #10;
      total++;
      if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
         bad++; $display("FAIL reset_init: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
      end
      reset = 1;
      @(posedge clk); #1;
      mt(1, 1, 32'h33, 0);
      md_op = 3'd2; rs_data = 32'd100; rt_data = 32'd7; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL reset_pre_busy: got %b expected 1", busy); end
      #2 reset = 0;
      #1;
      total++;
      if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
         bad++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
      end
      #2 reset = 1;
      m_hi = 0; m_lo = 0;
      n = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (busy) n++;
      end
      total++;
      if (n != 0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
         bad++; $display("FAIL reset_no_commit: busy_cycles=%0d hi=%h lo=%h expected 0 0 0", n, hi_out, lo_out);
      end
   endtask

   task automatic test_mult;
      issue(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0);
      issue(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
      issue(3'd0, 32'h80000000, 32'h80000000, 0, 0);
   endtask

   task automatic test_div;
      issue(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
      issue(3'd3, 32'd7, 32'd2, 0, 0);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      issue(3'd2, 32'd7, 32'hFFFFFFFE, 0, 0);
   endtask

   task automatic test_divzero;
      mt(1, 0, 32'h11, 0);
      mt(0, 1, 32'h22, 0);
      issue(3'd2, 32'd55, 32'd0, 0, 0);
      issue(3'd3, 32'd55, 32'd0, 0, 0);
   endtask

   task automatic test_req;
      issue(3'd0, 32'd9, 32'd9, 1, 0);
      mt(1, 1, 32'hDEAD, 1);
      issue(3'd6, 32'd9, 32'd9, 0, 0);
   endtask

   task automatic test_busy_writes;
      issue(3'd3, 32'd7, 32'd2, 0, 1);
      mt(0, 1, 32'd5, 0);
   endtask

   task automatic test_madd;
      mt(1, 1, 32'd0, 0);
      mt(0, 1, 32'hFFFFFFFF, 0);
      issue(3'd5, 32'd1, 32'd1, 0, 0);
      issue(3'd4, 32'hFFFFFFFF, 32'd3, 0, 0);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 10; i++)
         issue(3'($urandom_range(0, 7)), $urandom, (i == 4) ? 32'd0 : $urandom, 0, 0);
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_divzero;
      test_req;
      test_busy_writes;
      test_madd;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
